// File: rtl/serial_link_credit_ctrl_if.sv
// serial_link_credit_ctrl_if: link-layer and PHY handshake bundle for the credit controller
// slave modport is the controller's view, master modport the surrounding logic's view.
// data_out*/data_in*: link-layer payload out/in; phy_out*/phy_in*: PHY words {credit, pl_valid, payload}.
interface serial_link_credit_if #(
    parameter int DataWidth = 16,
    parameter int CreditW   = 4
);
    localparam int PhyW = DataWidth + 1 + CreditW;
    logic [DataWidth-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic [PhyW-1:0]      phy_out;
    logic                 phy_out_valid;
    logic                 phy_out_ready;
    logic [PhyW-1:0]      phy_in;
    logic                 phy_in_valid;
    logic                 phy_in_ready;
    logic [DataWidth-1:0] data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    modport slave (
        input  data_out, data_out_valid, phy_out_ready, phy_in, phy_in_valid, data_in_ready,
        output data_out_ready, phy_out, phy_out_valid, phy_in_ready, data_in, data_in_valid
    );
    modport master (
        output data_out, data_out_valid, phy_out_ready, phy_in, phy_in_valid, data_in_ready,
        input  data_out_ready, phy_out, phy_out_valid, phy_in_ready, data_in, data_in_valid
    );
endinterface

// File: rtl/serial_link_credit_ctrl.sv
// serial_link_credit_ctrl: credit-based flow control between link layer and PHY
// clk_i/rst_ni: clock, async active-low reset; bus: handshake bundle (slave view);
// tx_credit_o: remote credits; credit_err_o/rx_overflow_o: sticky error flags.
module serial_link_credit_ctrl #(
    parameter int NumCredits       = 8,
    parameter int DataWidth        = 16,
    parameter int CreditOnlyThresh = NumCredits / 2,
    localparam int CreditW         = $clog2(NumCredits + 1),
    localparam int PhyW            = DataWidth + 1 + CreditW,
    localparam int PtrW            = $clog2(NumCredits)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    serial_link_credit_if.slave bus,
    output logic [CreditW-1:0] tx_credit_o,
    output logic               credit_err_o,
    output logic               rx_overflow_o
);
    localparam logic [CreditW:0] MaxCredit = (CreditW + 1)'(NumCredits);
    logic [CreditW-1:0]   tx_credit_q, tx_credit_d, pend_q, pend_d, cnt_q, cnt_d, rx_credit, captured;
    logic [CreditW:0]     tx_sum;
    logic                 out_valid_q, out_valid_d, credit_err_q, credit_err_d, rx_ovf_q, rx_ovf_d;
    logic [PhyW-1:0]      out_q, out_d;
    logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [DataWidth-1:0] mem_q [NumCredits];
    logic                 load, load_pl, credit_only, pop, pl_in, push, full;
    // Ready outputs are forced low while reset is asserted.
    assign bus.phy_in_ready   = rst_ni;
    assign bus.data_out_ready = rst_ni && load && tx_credit_q != '0;
    assign bus.phy_out        = out_q;
    assign bus.phy_out_valid  = out_valid_q;
    assign bus.data_in_valid  = cnt_q != '0;
    assign bus.data_in        = bus.data_in_valid ? mem_q[rd_q] : '0;
    assign tx_credit_o        = tx_credit_q;
    assign credit_err_o       = credit_err_q;
    assign rx_overflow_o      = rx_ovf_q;
    always_comb begin
        load        = !out_valid_q || bus.phy_out_ready;
        load_pl     = bus.data_out_valid && bus.data_out_ready;
        credit_only = pend_q >= CreditW'(CreditOnlyThresh);
        captured    = (load && (load_pl || credit_only)) ? pend_q : '0;
        pop         = bus.data_in_valid && bus.data_in_ready;
        pend_d      = pend_q - captured + CreditW'(pop);
        out_valid_d = load ? (load_pl || credit_only) : out_valid_q;
        out_d       = !load       ? out_q :
                      load_pl     ? {pend_q, 1'b1, bus.data_out} :
                      credit_only ? {pend_q, 1'b0, {DataWidth{1'b0}}} : '0;
        // Credit field only counts on an accepted PHY word; phy_in is always ready.
        rx_credit    = bus.phy_in_valid ? bus.phy_in[PhyW-1 -: CreditW] : '0;
        tx_sum       = {1'b0, tx_credit_q} - {{CreditW{1'b0}}, load_pl} + {1'b0, rx_credit};
        tx_credit_d  = (tx_sum > MaxCredit) ? CreditW'(NumCredits) : tx_sum[CreditW-1:0];
        credit_err_d = credit_err_q || tx_sum > MaxCredit;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
        full     = cnt_q == CreditW'(NumCredits);
        pl_in    = bus.phy_in_valid && bus.phy_in[DataWidth];
        push     = pl_in && (!full || pop);
        rx_ovf_d = rx_ovf_q || (pl_in && !push);
        cnt_d    = cnt_q + CreditW'(push) - CreditW'(pop);
        wr_d     = !push ? wr_q : (wr_q == PtrW'(NumCredits - 1)) ? '0 : wr_q + PtrW'(1);
        rd_d     = !pop  ? rd_q : (rd_q == PtrW'(NumCredits - 1)) ? '0 : rd_q + PtrW'(1);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_credit_q  <= CreditW'(NumCredits);
            pend_q       <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            credit_err_q <= 1'b0;
            rx_ovf_q     <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            tx_credit_q  <= tx_credit_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            credit_err_q <= credit_err_d;
            rx_ovf_q     <= rx_ovf_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= bus.phy_in[DataWidth-1:0];
    end
endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// tb_serial_link_credit_ctrl: directed scoreboard bench for serial_link_credit_ctrl
module tb_serial_link_credit_ctrl;
    localparam int NC = 8, DW = 16, CW = 4, PW = DW + 1 + CW;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    serial_link_credit_if #(.DataWidth(DW), .CreditW(CW)) bus();
    logic [CW-1:0] tx_credit;
    logic credit_err, rx_overflow;
    serial_link_credit_ctrl #(.NumCredits(NC), .DataWidth(DW), .CreditOnlyThresh(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .tx_credit_o(tx_credit), .credit_err_o(credit_err), .rx_overflow_o(rx_overflow)
    );
    typedef struct {logic [PW-1:0] w; int due;} exp_t;
    exp_t phy_q[$];
    logic [DW-1:0] rx_q[$];
    int nvec = 0, nerr = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [PW-1:0] pw(int c, bit pl, logic [DW-1:0] d);
        return {CW'(c), pl, d};
    endfunction
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        logic [DW-1:0] r;
        if (rst_n) begin
            if (bus.phy_out_valid && bus.phy_out_ready) begin
                if (phy_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL phy_unexpected: got %0h expected none", bus.phy_out);
                end else begin
                    e = phy_q.pop_front();
                    chk("phy_word", 32'(bus.phy_out), 32'(e.w));
                    if (e.due >= 0) chk("phy_cycle", cyc, e.due);
                end
            end
            if (bus.data_in_valid && bus.data_in_ready) begin
                if (rx_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rx_unexpected: got %0h expected none", bus.data_in);
                end else begin
                    r = rx_q.pop_front();
                    chk("rx_word", 32'(bus.data_in), 32'(r));
                end
            end
        end
    end
    initial begin
        bus.data_out = '0; bus.data_out_valid = 0; bus.phy_out_ready = 0;
        bus.phy_in = '0; bus.phy_in_valid = 0; bus.data_in_ready = 0;
        @(negedge clk);
        chk("rst_data_out_ready", bus.data_out_ready, 0);
        chk("rst_phy_in_ready", bus.phy_in_ready, 0);
        chk("rst_phy_out_valid", bus.phy_out_valid, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rel_tx_credit", tx_credit, 8);
        chk("rel_phy_out_valid", bus.phy_out_valid, 0);
        chk("rel_phy_out", 32'(bus.phy_out), 0);
        chk("rel_phy_in_ready", bus.phy_in_ready, 1);
        chk("rel_data_in_valid", bus.data_in_valid, 0);
        chk("rel_data_in", bus.data_in, 0);
        chk("rel_errs", {credit_err, rx_overflow}, 0);
        tick();
        // Eight payloads exhaust the remote credits
        bus.phy_out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            bus.data_out = DW'(16'hA000 + i);
            bus.data_out_valid = 1;
            @(negedge clk);
            chk("send_ready", bus.data_out_ready, 1);
            phy_q.push_back('{pw(0, 1, DW'(16'hA000 + i)), cyc + 1});
            tick();
        end
        bus.data_out = 16'hA008;
        @(negedge clk);
        chk("ninth_ready", bus.data_out_ready, 0);
        chk("ninth_credit", tx_credit, 0);
        tick();
        bus.data_out_valid = 0;
        // Credit return coinciding with a payload load
        bus.phy_in = pw(1, 0, 0); bus.phy_in_valid = 1;
        @(negedge clk);
        tick();
        bus.phy_in = pw(3, 0, 0);
        bus.data_out = 16'hB001; bus.data_out_valid = 1;
        @(negedge clk);
        chk("net_credit_before", tx_credit, 1);
        chk("net_ready", bus.data_out_ready, 1);
        phy_q.push_back('{pw(0, 1, 16'hB001), cyc + 1});
        tick();
        bus.phy_in_valid = 0; bus.data_out_valid = 0;
        @(negedge clk);
        chk("net_credit_after", tx_credit, 3);
        tick();
        // Receive five, pop four: one credit-only word
        for (int i = 0; i < 5; i++) begin
            bus.phy_in = pw(0, 1, DW'(16'hC000 + i)); bus.phy_in_valid = 1;
            rx_q.push_back(DW'(16'hC000 + i));
            tick();
        end
        bus.phy_in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            bus.data_in_ready = 1;
            @(negedge clk);
            if (i == 3) phy_q.push_back('{pw(4, 0, 0), cyc + 2});
            tick();
        end
        bus.data_in_ready = 0;
        repeat (4) tick();
        @(negedge clk);
        chk("credit_only_once", bus.phy_out_valid, 0);
        tick();
        // Stall with a payload held while pops accumulate
        bus.phy_out_ready = 0;
        bus.data_out = 16'hD001; bus.data_out_valid = 1;
        @(negedge clk);
        chk("stall_load_ready", bus.data_out_ready, 1);
        phy_q.push_back('{pw(0, 1, 16'hD001), -1});
        tick();
        bus.data_out = 16'hD002;
        for (int k = 0; k < 10; k++) begin
            bus.data_in_ready = (k == 0 || k == 2 || k == 4);
            bus.phy_in_valid = (k == 1 || k == 3);
            bus.phy_in = pw(0, 1, (k == 1) ? 16'hE001 : 16'hE002);
            if (bus.phy_in_valid) rx_q.push_back(bus.phy_in[DW-1:0]);
            @(negedge clk);
            chk("stall_word", 32'(bus.phy_out), 32'(pw(0, 1, 16'hD001)));
            chk("stall_ready", bus.data_out_ready, 0);
            tick();
        end
        bus.data_in_ready = 0; bus.phy_in_valid = 0;
        bus.phy_out_ready = 1;
        @(negedge clk);
        chk("unstall_ready", bus.data_out_ready, 1);
        phy_q.push_back('{pw(3, 1, 16'hD002), cyc + 1});
        tick();
        bus.data_out_valid = 0;
        @(negedge clk);
        chk("unstall_credit", tx_credit, 1);
        tick();
        // Overflow and credit saturation
        for (int i = 0; i < 9; i++) begin
            bus.phy_in = pw(0, 1, DW'(16'hF000 + i)); bus.phy_in_valid = 1;
            if (i < 8) rx_q.push_back(DW'(16'hF000 + i));
            @(negedge clk);
            if (i == 8) chk("ovf_before", rx_overflow, 0);
            tick();
        end
        bus.phy_in_valid = 0;
        @(negedge clk);
        chk("ovf_after", rx_overflow, 1);
        tick();
        bus.phy_in = pw(7, 0, 0); bus.phy_in_valid = 1;
        tick();
        bus.phy_in = pw(8, 0, 0);
        @(negedge clk);
        chk("sat_credit_before", tx_credit, 8);
        chk("sat_err_before", credit_err, 0);
        tick();
        bus.phy_in_valid = 0;
        @(negedge clk);
        chk("sat_credit_after", tx_credit, 8);
        chk("sat_err_after", credit_err, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.data_in_ready = 1;
            @(negedge clk);
            if (i == 3 || i == 7) phy_q.push_back('{pw(4, 0, 0), cyc + 2});
            tick();
        end
        bus.data_in_ready = 0;
        for (int t = 0; t < 20 && (phy_q.size() + rx_q.size()) != 0; t++) tick();
        @(negedge clk);
        chk("drained", phy_q.size() + rx_q.size(), 0);
        chk("empty_at_end", bus.data_in_valid, 0);
        chk("sticky_errs", {credit_err, rx_overflow}, 2'b11);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/serial_link_credit_ctrl.md
# serial_link_credit_ctrl

Credit-based flow-control stage between the serial link's data-link layer and the physical layer, in the system clock domain. Outbound, it gates payload words by the remote receiver's available buffer credits and piggybacks locally returned credits on every PHY word. Inbound, it buffers received payload in a NumCredits-deep FIFO and counts credits as the consumer pops. It closes the loop that lets the PHY RX CDC FIFO run without backpressure.

## Interface
- NumCredits, default 8: remote and local receive buffer depth in words; range 2..32.
- DataWidth, default 16: payload width, equal to NumLanes*2 in DDR mode.
- CreditOnlyThresh, default NumCredits/2: pending-return count that forces a credit-only word; range 1..NumCredits.
- Derived: CreditW = $clog2(NumCredits+1); PhyW = DataWidth+1+CreditW; PHY word = {credit[CreditW-1:0], pl_valid, payload[DataWidth-1:0]}.
- clk_i  in  1  system clock (single clock).
- rst_ni  in  1  asynchronous active-low reset.
- data_out_i  in  DataWidth  payload from link layer.
- data_out_valid_i  in  1  payload valid.
- data_out_ready_o  out  1  payload accepted.
- phy_out_o  out  PhyW  word to PHY TX.
- phy_out_valid_o  out  1  PHY word valid.
- phy_out_ready_i  in  1  PHY TX ready.
- phy_in_i  in  PhyW  word from PHY RX CDC.
- phy_in_valid_i  in  1  received word valid.
- phy_in_ready_o  out  1  constant 1 out of reset.
- data_in_o  out  DataWidth  received payload to link layer.
- data_in_valid_o  out  1  received payload valid.
- data_in_ready_i  in  1  link layer pops.
- tx_credit_o  out  CreditW  current remote credits.
- credit_err_o  out  1  sticky: tx credit would exceed NumCredits.
- rx_overflow_o  out  1  sticky: payload received with local FIFO full.

## Operation
- tx_credit_q: resets to NumCredits. Each cycle: tx_credit_d = tx_credit_q - load_pl + rx_credit_field, where rx_credit_field counts only on a phy_in handshake. If the result exceeds NumCredits, saturate at NumCredits and set credit_err_o.
- pend_q (credits owed to remote): resets to 0. pend_d = pend_q - captured + pop, where captured is pend_q at output-register load and pop is the data_in handshake.
- Output register (valid, word): load when empty or on a phy_out handshake.
  - Priority 1 (payload): data_out_valid_i && tx_credit_q != 0. Load {pend_q, 1, data_out_i}. data_out_ready_o = 1 that cycle; load_pl = 1.
  - Priority 2 (credit-only): pend_q >= CreditOnlyThresh. Load {pend_q, 0, '0}.
  - Otherwise clear valid.
- data_out_ready_o is combinational: (reg empty or phy_out_ready_i) && tx_credit_q != 0.
- The word is held stable while phy_out_valid_o && !phy_out_ready_i.
- Receive: every phy_in_valid_i cycle is accepted.
  - If pl_valid and the FIFO is not full, push the payload.
  - If pl_valid and the FIFO is full, drop the word and set rx_overflow_o. The credit field is still applied.
- RX FIFO: NumCredits deep, first-word-fall-through. data_in_valid_o = !empty. Push and pop in the same cycle are legal when full or empty.
- Sticky error flags are cleared only by reset.

## Timing
- Reset values:
  - phy_out_valid_o = 0, phy_out_o = 0, data_out_ready_o = 0.
  - data_in_valid_o = 0, data_in_o = 0.
  - tx_credit_o = NumCredits, phy_in_ready_o = 1 (0 while rst_ni is low).
  - Both error flags = 0.
- Payload latency: data_out handshake in cycle N gives phy_out_valid_o in cycle N+1.
- Received payload: phy_in handshake in cycle N gives data_in_valid_o in cycle N+1.
- Credit return: a pop in cycle N is counted in pend_q at N+1. It can be captured in a load at N+1 and appears on phy_out_o at N+2.
- A received credit in cycle N is usable in tx_credit_q at N+1.
- Simultaneous load_pl and received credit in one cycle: net update, no loss.
- Reset mid-transfer: all state is discarded immediately (asynchronous). The remote side is reset together.

## Test plan
- Reset release, NumCredits=8: tx_credit_o=8, phy_out_valid_o=0, phy_in_ready_o=1, data_in_valid_o=0.
- Send 8 payloads with phy_out_ready_i=1 and no incoming credits: 8 words with pl_valid=1, each phy_out one cycle after its handshake. The 9th data_out_valid_i sees data_out_ready_o=0 and tx_credit_o=0.
- Inject phy_in word {credit=3, pl_valid=0} while a payload loads in the same cycle from tx_credit=1: next cycle tx_credit_o=3.
- Receive 5 payloads, then pop 4 with no local traffic, thresh=4: exactly one credit-only word {credit=4, pl_valid=0} appears two cycles after the 4th pop, then pend returns to 0.
- Stall phy_out_ready_i=0 for 10 cycles with a payload loaded while pops occur: phy_out_o stays constant. Pops accumulate in pend_q and ride on the next word.
- Push 9 payloads with no pops (NumCredits=8): rx_overflow_o=1 after the 9th, FIFO contents are the first 8 words in order. Credit {credit=8} received at tx_credit=8 sets credit_err_o=1, and tx_credit_o stays 8.
